// File: rtl/pipe_mux_if.sv
// pipe_mux_if: upstream/downstream handshake bundle for pipe_mux.
// master = side that offers channels and sinks beats; slave = the mux itself.
interface pipe_mux_if #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned NUM_IN = 3,
    parameter int unsigned SEL_W  = 2
);
    logic [NUM_IN*WIDTH-1:0] in_data;
    logic [SEL_W-1:0]        in_sel;
    logic                    in_valid;
    logic                    in_ready;
    logic [WIDTH-1:0]        out_data;
    logic                    out_valid;
    logic                    out_ready;

    modport master (
        output in_data, in_sel, in_valid, out_ready,
        input  in_ready, out_data, out_valid
    );

    modport slave (
        input  in_data, in_sel, in_valid, out_ready,
        output in_ready, out_data, out_valid
    );
endinterface

// File: rtl/pipe_mux.sv
// pipe_mux: selects one of NUM_IN packed channels at input acceptance and
// delivers it through a 2-entry (output + skid) registered pipeline stage.
// Optional macro PIPE_MUX_SEL_CHECK_EN adds a sticky sel_err output that
// flags any accepted beat whose select is out of range.
module pipe_mux #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned NUM_IN = 3,
    parameter int unsigned SEL_W  = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    pipe_mux_if.slave   bus,
    output logic [15:0] beat_cnt
`ifdef PIPE_MUX_SEL_CHECK_EN
    ,
    output logic        sel_err
`endif
);

    localparam int unsigned CNT_W = 16;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] out_d;
    logic [WIDTH-1:0] skid_q;
    logic [WIDTH-1:0] skid_d;
    logic             out_valid_q;
    logic             out_valid_d;
    logic             in_ready_q;
    logic             in_ready_d;

    logic             in_fire_c;
    logic             out_fire_c;
    logic [WIDTH-1:0] chan_word_c;
    logic [WIDTH-1:0] sel_word_c;
    logic             sel_hit_c;

    assign in_fire_c     = bus.in_valid && in_ready_q;
    assign out_fire_c    = out_valid_q && bus.out_ready;
    assign bus.in_ready  = in_ready_q;
    assign bus.out_data  = out_q;
    assign bus.out_valid = out_valid_q;

    // Channel select; an index with no matching channel yields zero
    always_comb begin
        chan_word_c = '0;
        sel_hit_c   = 1'b0;
        for (int unsigned k = 0; k < NUM_IN; k++) begin
            if (bus.in_sel == SEL_W'(k)) begin
                chan_word_c = bus.in_data[k*WIDTH +: WIDTH];
                sel_hit_c   = 1'b1;
            end
        end
        sel_word_c = sel_hit_c ? chan_word_c : '0;
    end

    // Occupancy state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Occupancy next-state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (in_fire_c) state_d = ST_ONE;
            ST_ONE: begin
                if (in_fire_c && !out_fire_c)      state_d = ST_FULL;
                else if (!in_fire_c && out_fire_c) state_d = ST_EMPTY;
            end
            ST_FULL:  if (out_fire_c) state_d = ST_ONE;
            default:  state_d = ST_EMPTY;
        endcase
    end

    // Datapath and handshake next values; out_d clears whenever the stage drains
    always_comb begin
        out_d       = out_q;
        skid_d      = skid_q;
        out_valid_d = (state_d != ST_EMPTY);
        in_ready_d  = (state_d != ST_FULL);
        case (state_q)
            ST_EMPTY: begin
                if (in_fire_c) out_d = sel_word_c;
            end
            ST_ONE: begin
                if (in_fire_c && out_fire_c) out_d  = sel_word_c;
                else if (in_fire_c)          skid_d = sel_word_c;
                else if (out_fire_c)         out_d  = '0;
            end
            ST_FULL: begin
                if (out_fire_c) begin
                    out_d  = skid_q;
                    skid_d = '0;
                end
            end
            default: begin
                out_d  = '0;
                skid_d = '0;
            end
        endcase
    end

    // Datapath and handshake registers; in_ready held low during reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q       <= '0;
            skid_q      <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
        end else begin
            out_q       <= out_d;
            skid_q      <= skid_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    // Delivered-beat counter, wraps naturally at 16 bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt <= '0;
        end else if (out_fire_c) begin
            beat_cnt <= beat_cnt + CNT_W'(1);
        end
    end

`ifdef PIPE_MUX_SEL_CHECK_EN
    // Sticky flag for accepted out-of-range selects
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_err <= 1'b0;
        end else if (in_fire_c && !sel_hit_c) begin
            sel_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_mux.sv
// tb_pipe_mux: randomized + directed bench with a queue scoreboard for pipe_mux.
module tb_pipe_mux;

    localparam int unsigned WIDTH  = 32;
    localparam int unsigned NUM_IN = 3;
    localparam int unsigned SEL_W  = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] beat_cnt;
`ifdef PIPE_MUX_SEL_CHECK_EN
    logic        sel_err;
`endif

    pipe_mux_if #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .SEL_W(SEL_W)) bus ();

    pipe_mux #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .SEL_W(SEL_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .beat_cnt (beat_cnt)
`ifdef PIPE_MUX_SEL_CHECK_EN
        ,
        .sel_err  (sel_err)
`endif
    );

    always #5 clk = ~clk;

    int unsigned      vectors = 0;
    int unsigned      miscompares = 0;
    logic [WIDTH-1:0] exp_q[$];
    logic [15:0]      model_cnt = '0;
    bit               ready_armed;
    bit               exp_err = 1'b0;
    int unsigned      acc_total = 0;
    int unsigned      dlv_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: channel value, or zero for an index with no channel
    function automatic logic [WIDTH-1:0] ref_word(input logic [NUM_IN*WIDTH-1:0] d,
                                                  input logic [SEL_W-1:0] s);
        int idx;
        idx = int'(s);
        if (idx >= int'(NUM_IN)) return '0;
        return d[idx*WIDTH +: WIDTH];
    endfunction

    // in_ready may only rise at the first edge after reset release
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) ready_armed <= 1'b0;
        else        ready_armed <= 1'b1;
    end

    // Monitor/scoreboard: occupancy = outstanding accepted beats
    always @(negedge clk) begin
        int unsigned occ;
        if (!rst_n) begin
            exp_q.delete();
            model_cnt = '0;
            exp_err   = 1'b0;
            chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
            chk("rst_out_data", bus.out_data, 32'd0);
            chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
            chk("rst_beat_cnt", 32'(beat_cnt), 32'd0);
        end else begin
            occ = exp_q.size();
            chk("in_ready", 32'(bus.in_ready), 32'(ready_armed && occ < 2));
            chk("out_valid", 32'(bus.out_valid), 32'(occ > 0));
            if (occ > 0) chk("out_data", bus.out_data, exp_q[0]);
            else         chk("out_data_idle", bus.out_data, 32'd0);
            chk("beat_cnt", 32'(beat_cnt), 32'(model_cnt));
`ifdef PIPE_MUX_SEL_CHECK_EN
            chk("sel_err", 32'(sel_err), 32'(exp_err));
`endif
            if (bus.out_valid && bus.out_ready && occ > 0) begin
                void'(exp_q.pop_front());
                model_cnt = model_cnt + 16'd1;
                dlv_total++;
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(ref_word(bus.in_data, bus.in_sel));
                if (32'(bus.in_sel) >= NUM_IN) exp_err = 1'b1;
                acc_total++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8 && bus.out_valid; i++) step();
        chk(name, 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned base;
        bit          mid_seen;
        bus.in_data   = '0;
        bus.in_sel    = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("in_ready_before_edge", 32'(bus.in_ready), 32'd0);
        step();
        chk("in_ready_after_edge", 32'(bus.in_ready), 32'd1);

        // Streaming three channels with downstream ready
        bus.in_data   = {32'hC15C1C1C, 32'hA1B2C3D4, 32'h001142B3};
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_sel    = 2'd0; step(); chk("t1_beat0", bus.out_data, 32'h001142B3);
        bus.in_sel    = 2'd1; step(); chk("t1_beat1", bus.out_data, 32'hA1B2C3D4);
        bus.in_sel    = 2'd2; step(); chk("t1_beat2", bus.out_data, 32'hC15C1C1C);
        bus.in_valid  = 1'b0; step(); chk("t1_beat_cnt", 32'(beat_cnt), 32'd3);

        // Backpressure: fill to full, hold, then release in order
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_sel    = 2'd0; step(); chk("t2_hold0", bus.out_data, 32'h001142B3);
        bus.in_sel    = 2'd1; step(); chk("t2_full_ready", 32'(bus.in_ready), 32'd0);
        chk("t2_hold1", bus.out_data, 32'h001142B3);
        bus.in_sel    = 2'd2; step(); chk("t2_hold2", bus.out_data, 32'h001142B3);
        chk("t2_still_full", 32'(bus.in_ready), 32'd0);
        bus.out_ready = 1'b1; step(); chk("t2_skid_move", bus.out_data, 32'hA1B2C3D4);
        chk("t2_ready_back", 32'(bus.in_ready), 32'd1);
        step();               chk("t2_third", bus.out_data, 32'hC15C1C1C);
        bus.in_valid  = 1'b0; step(); chk("t2_empty", 32'(bus.out_valid), 32'd0);
        chk("t2_beat_cnt", 32'(beat_cnt), 32'd6);

        // Out-of-range select passes as zero
        bus.in_valid = 1'b1;
        bus.in_sel   = 2'd3; step(); chk("t3_oob_data", bus.out_data, 32'd0);
        chk("t3_oob_valid", 32'(bus.out_valid), 32'd1);
        bus.in_sel   = 2'd0; step(); chk("t3_legal_after", bus.out_data, 32'h001142B3);
        bus.in_valid = 1'b0; step(); step();
`ifdef PIPE_MUX_SEL_CHECK_EN
        chk("t3_sel_err_sticky", 32'(sel_err), 32'd1);
`endif

        // Reset while full discards held beats
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_sel    = 2'd1; step();
        bus.in_sel    = 2'd2; step();
        bus.in_valid  = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("t4_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("t4_rst_data", bus.out_data, 32'd0);
        chk("t4_rst_cnt", 32'(beat_cnt), 32'd0);
        chk("t4_rst_ready", 32'(bus.in_ready), 32'd0);
        step(); step();
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        step(); chk("t4_ready_after", 32'(bus.in_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            step(); chk("t4_no_stale", 32'(bus.out_valid), 32'd0);
        end

        // Continuous input with out_ready toggling
        bus.in_valid = 1'b1;
        for (int i = 0; i < 24; i++) begin
            bus.in_sel    = SEL_W'($urandom_range(0, 2));
            bus.in_data   = {$urandom, $urandom, $urandom};
            bus.out_ready = (i % 2 == 0);
            step();
        end
        drain("t5_drain");

        // Randomized traffic, including data changes while stalled
        for (int i = 0; i < 3000; i++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.in_sel    = SEL_W'($urandom_range(0, 3));
            bus.in_data   = {$urandom, $urandom, $urandom};
            bus.out_ready = ($urandom_range(0, 2) != 0);
            step();
        end
        drain("t6_drain");

        // Counter wrap after 65536 deliveries from reset
        rst_n = 1'b0; step(); rst_n = 1'b1; step();
        base = acc_total;
        mid_seen = 1'b0;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        for (int i = 0; i < 70000 && (acc_total - base) < 65536; i++) begin
            bus.in_sel  = SEL_W'($urandom_range(0, 2));
            bus.in_data = {$urandom, $urandom, $urandom};
            step();
            if (!mid_seen && (acc_total - base) >= 65535) begin
                mid_seen = 1'b1;
                chk("t7_cnt_fffe", 32'(beat_cnt), 32'h0000FFFE);
            end
        end
        bus.in_valid = 1'b0;
        chk("t7_accepted", acc_total - base, 32'd65536);
        drain("t7_drain");
        chk("t7_cnt_wrap", 32'(beat_cnt), 32'h00000000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pipe_mux.md
PIPE_MUX -- requirements
Module: pipe_mux

Interface
REQ-001 Parameter WIDTH, default 32, data width of each input channel and of the output.
REQ-002 Parameter NUM_IN, default 3, number of input channels; legal range 2..16.
REQ-003 Parameter SEL_W, default 2, select width; SHALL satisfy 2**SEL_W >= NUM_IN.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 in_data  input  NUM_IN*WIDTH  packed channels; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-007 in_sel  input  SEL_W  channel index, sampled with in_data.
REQ-008 in_valid  input  1  upstream offers a beat.
REQ-009 in_ready  output  1  block can accept a beat this cycle.
REQ-010 out_data  output  WIDTH  selected channel, registered.
REQ-011 out_valid  output  1  out_data holds a valid beat.
REQ-012 out_ready  input  1  downstream accepts the beat.
REQ-013 beat_cnt  output  16  count of beats delivered downstream.
REQ-014 sel_err  output  1  sticky out-of-range select flag (present only per REQ-030).

Function
REQ-015 An input transfer SHALL occur on a rising edge with in_valid && in_ready; an output transfer with out_valid && out_ready.
REQ-016 Selection SHALL be performed at input acceptance: captured word = channel in_sel of in_data.
REQ-017 Latency SHALL be 1 cycle: with an empty block, a beat accepted at edge N appears on out_data/out_valid after edge N.
REQ-018 Storage SHALL be one output register plus one skid register (2 entries total); occupancy states EMPTY(0), ONE(1), FULL(2).
REQ-019 Transitions: EMPTY->ONE on input only; ONE->FULL on input without output; ONE->EMPTY on output without input; FULL->ONE on output; simultaneous input+output in ONE stays ONE.
REQ-020 in_ready SHALL be registered, high in EMPTY and ONE, low in FULL; no combinational path from out_ready to in_ready.
REQ-021 On output transfer in FULL, the skid word SHALL move to the output register on the same edge; order SHALL be preserved.
REQ-022 While out_valid && !out_ready, out_data and out_valid SHALL stay unchanged.
REQ-023 When out_valid is low, out_data SHALL read 0.
REQ-024 beat_cnt SHALL increment by 1 per output transfer, wrapping 16'hFFFF -> 16'h0000.
REQ-025 in_sel >= NUM_IN SHALL select the value 0.
REQ-026 in_data/in_sel changes while in_ready is low SHALL have no effect.

Reset
REQ-027 rst_n low SHALL immediately clear: state EMPTY, out_valid 0, out_data 0, skid word 0, beat_cnt 0, sel_err 0.
REQ-028 in_ready SHALL be 0 while rst_n is low and 1 from the first rising edge after release.
REQ-029 Reset asserted mid-operation SHALL discard any held beats without delivering them.

Configuration
REQ-030 Macro PIPE_MUX_SEL_CHECK_EN: when defined, sel_err port exists and sets on any accepted beat with in_sel >= NUM_IN, cleared only by reset; when undefined, sel_err port is absent and out-of-range beats pass silently as 0 per REQ-025.

Verification
REQ-031 Reset release, NUM_IN=3, ch0=32'h001142B3 ch1=32'hA1B2C3D4 ch2=32'hC15C1C1C, out_ready=1, in_sel 0,1,2 on consecutive cycles -> out_data 001142B3, A1B2C3D4, C15C1C1C one cycle later each, beat_cnt=3.
REQ-032 out_ready=0, present 3 beats sel 0,1,2 -> beats 0,1 accepted, in_ready low after second, out_data held at 001142B3; raise out_ready -> A1B2C3D4 then C15C1C1C in order, no loss or duplicate.
REQ-033 in_sel=3 accepted -> out_data 0; with PIPE_MUX_SEL_CHECK_EN sel_err=1 and stays 1 through later legal beats.
REQ-034 Block FULL, assert rst_n low between edges -> out_valid=0, out_data=0, beat_cnt=0 immediately; after release in_ready=1, no stale beat appears.
REQ-035 Preload beat_cnt to 16'hFFFE via 2 fewer than 65536 transfers (or force), deliver 2 beats -> beat_cnt 16'h0000.
REQ-036 Continuous in_valid=1, out_ready toggling 1,0,1,0 -> one beat per out_ready-high cycle, throughput never stalls input while state is ONE.
